// File: rtl/sdram_pkg.sv
// Shared types for the ROM download path into one SDRAM request port.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package sdram_pkg;

  // One SDRAM write: word address, byte strobes {hi,lo}, data {odd,even}
  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } wr_word_t;

  typedef enum logic {IDLE, WAIT} wr_state_t;

  localparam logic [1:0] DS_BOTH = 2'b11;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_LO   = 2'b01;

  function automatic wr_word_t make_word(input logic [22:0] addr,
                                         input logic [1:0]  ds,
                                         input logic [7:0]  hi,
                                         input logic [7:0]  lo);
    wr_word_t w;
    w.addr = addr;
    w.ds   = ds;
    w.data = {hi, lo};
    return w;
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous FIFO of pending SDRAM write words.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push into a full FIFO drops the word (flagged in sim); pop on empty is ignored.
module sdram_wr_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wr_word_t                   push_word,
  input  logic                       pop,
  output wr_word_t                   head_word,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wr_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is fine then
  assign do_push   = push & (~full | do_pop);
  assign head_word = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop))
    else $error("sdram_wr_fifo: push into full FIFO, word dropped");

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs the ioctl byte stream into 16-bit SDRAM writes over a toggle req/ack port.
// Latency: a completed word reaches port_req two cycles after its last byte strobe when the port is idle.
// Backpressure: registered ioctl_wait rises at FIFO_DEPTH-1 entries and for one cycle after a flush collision.
module sdram_rom_loader
  import sdram_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] BASE_ADDR  = 23'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port_req,
  input  logic        port_ack,
  output logic        port_we,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Pack register: a held even byte, or an odd byte queued behind a flush
  logic        hold_vld, hold_vld_nxt;
  logic        hold_odd, hold_odd_nxt;
  logic [22:0] hold_addr, hold_addr_nxt;
  logic [7:0]  hold_byte, hold_byte_nxt;

  logic        wr_acc;
  logic        wr_odd;
  logic [22:0] wr_waddr;
  logic        collision;
  logic        push_vld;
  wr_word_t    push_word;

  logic        pop_vld;
  wr_word_t    head_word;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic        fifo_full;
  logic        fifo_empty;

  wr_state_t   state_q, state_nxt;
  logic        issue;
  logic        dl_q;
  logic        wait_q;
  logic        done_q;
  logic        req_q;
  logic [22:0] a_q;
  logic [1:0]  ds_q;
  logic [15:0] d_q;

  assign port_we    = 1'b1;
  assign port_req   = req_q;
  assign port_a     = a_q;
  assign port_ds    = ds_q;
  assign port_d     = d_q;
  assign ioctl_wait = wait_q;
  assign done       = done_q;

  assign wr_acc   = ioctl_wr & ioctl_download & ~wait_q;
  assign wr_odd   = ioctl_addr[0];
  assign wr_waddr = BASE_ADDR + ioctl_addr[24:1];

  // Byte packing: decide this cycle's push and the next pack register contents
  always_comb begin
    hold_vld_nxt  = hold_vld;
    hold_odd_nxt  = hold_odd;
    hold_addr_nxt = hold_addr;
    hold_byte_nxt = hold_byte;
    collision     = 1'b0;
    push_vld      = 1'b0;
    push_word     = '0;
    if (hold_vld && hold_odd) begin
      // Second half of a collision; ioctl_wait is high so no strobe competes
      push_vld     = 1'b1;
      push_word    = make_word(hold_addr, DS_HI, hold_byte, 8'h00);
      hold_vld_nxt = 1'b0;
      hold_odd_nxt = 1'b0;
    end else if (wr_acc) begin
      if (!wr_odd) begin
        if (hold_vld) begin
          push_vld  = 1'b1;
          push_word = make_word(hold_addr, DS_LO, 8'h00, hold_byte);
          collision = 1'b1;
        end
        hold_vld_nxt  = 1'b1;
        hold_odd_nxt  = 1'b0;
        hold_addr_nxt = wr_waddr;
        hold_byte_nxt = ioctl_dout;
      end else if (hold_vld && (hold_addr == wr_waddr)) begin
        push_vld     = 1'b1;
        push_word    = make_word(wr_waddr, DS_BOTH, ioctl_dout, hold_byte);
        hold_vld_nxt = 1'b0;
      end else if (hold_vld) begin
        push_vld      = 1'b1;
        push_word     = make_word(hold_addr, DS_LO, 8'h00, hold_byte);
        collision     = 1'b1;
        hold_vld_nxt  = 1'b1;
        hold_odd_nxt  = 1'b1;
        hold_addr_nxt = wr_waddr;
        hold_byte_nxt = ioctl_dout;
      end else begin
        push_vld  = 1'b1;
        push_word = make_word(wr_waddr, DS_HI, ioctl_dout, 8'h00);
      end
    end else if (hold_vld && !ioctl_download) begin
      // Download ended with a lone even byte: write it by itself
      push_vld     = 1'b1;
      push_word    = make_word(hold_addr, DS_LO, 8'h00, hold_byte);
      hold_vld_nxt = 1'b0;
    end
  end

  // Pack register state
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_odd  <= 1'b0;
      hold_addr <= '0;
      hold_byte <= '0;
    end else begin
      hold_vld  <= hold_vld_nxt;
      hold_odd  <= hold_odd_nxt;
      hold_addr <= hold_addr_nxt;
      hold_byte <= hold_byte_nxt;
    end
  end

  sdram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_vld),
    .push_word (push_word),
    .pop       (pop_vld),
    .head_word (head_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Occupancy after this cycle, so wait rises in the same cycle the count reaches the threshold
  assign count_nxt = fifo_count + CW'(push_vld & (~fifo_full | pop_vld)) - CW'(pop_vld);

  // HPS throttle, registered
  always_ff @(posedge clk) begin
    if (reset) wait_q <= 1'b0;
    else       wait_q <= (count_nxt >= CW'(FIFO_DEPTH - 1)) | collision;
  end

  // Writer FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Writer FSM next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (!fifo_empty)         state_nxt = WAIT;
      WAIT: if (port_ack == req_q)   state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Writer FSM outputs: issue a word from the FIFO head when idle
  always_comb begin
    issue   = (state_q == IDLE) && !fifo_empty;
    pop_vld = issue;
  end

  // Request port registers; held stable from the toggle until the ack matches
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= 1'b0;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
    end else if (issue) begin
      req_q <= ~req_q;
      a_q   <= head_word.addr;
      ds_q  <= head_word.ds;
      d_q   <= head_word.data;
    end
  end

  // Completion flag: sticky once drained, cleared when a new download starts
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (ioctl_download && !dl_q)
        done_q <= 1'b0;
      else if (!ioctl_download && !hold_vld && fifo_empty &&
               (state_q == IDLE) && (port_ack == req_q))
        done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_rom_loader.sv
module tb_sdram_rom_loader;
  import sdram_pkg::*;

  localparam logic [22:0] BASE = 23'h100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic        port_we;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        done;

  int checks = 0;
  int failures = 0;
  int n_writes = 0;
  int ack_lat = 3;
  int wait_rises = 0;
  logic cnt_chk_en = 1'b0;
  wr_word_t sb[$];

  sdram_rom_loader #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SDRAM controller model: capture each request, score it, ack after ack_lat cycles
  initial begin
    logic busy = 1'b0;
    int cnt = 0;
    wr_word_t got, exp;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        port_ack = 1'b0;
        busy = 1'b0;
      end else if (busy) begin
        if (cnt <= 0) begin
          port_ack = port_req;
          busy = 1'b0;
        end else cnt--;
      end else if (port_req != port_ack) begin
        busy = 1'b1;
        cnt = ack_lat;
        n_writes++;
        got = make_word(port_a, port_ds, port_d[15:8], port_d[7:0]);
        if (sb.size() == 0) exp = '0;
        else exp = sb.pop_front();
        check("write_word", 64'(got), 64'(exp));
      end
    end
  end

  // Wait-edge monitor; during the streaming step, wait must rise exactly at 3 entries
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ioctl_wait && !prev) begin
        wait_rises++;
        if (cnt_chk_en) check("wait_rise_count", 64'(dut.u_fifo.count), 64'd3);
      end
      prev = ioctl_wait;
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (ioctl_wait && t < 1000) begin
      ioctl_wr = 1'b0;
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  task automatic start_dl(input string tag);
    @(negedge clk);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk);
    check({tag, "_done_cleared"}, 64'(done), 64'd0);
  endtask

  task automatic end_dl(input string tag);
    int t = 0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w0;
    int t;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 64'(port_req), 64'd0);
    check("rst_a", 64'(port_a), 64'd0);
    check("rst_ds", 64'(port_ds), 64'd0);
    check("rst_d", 64'(port_d), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(port_we), 64'd1);
    reset = 1'b0;

    // Full word pair
    start_dl("pair");
    w0 = n_writes;
    sb.push_back(make_word(BASE + 23'd0, DS_BOTH, 8'h22, 8'h11));
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    end_dl("pair");
    check("pair_toggles", 64'(n_writes - w0), 64'd1);

    // Lone odd byte with base offset
    start_dl("odd");
    sb.push_back(make_word(BASE + 23'd2, DS_HI, 8'hAB, 8'h00));
    send_byte(25'd5, 8'hAB);
    end_dl("odd");

    // Lone even byte flushed at download end
    start_dl("tail");
    sb.push_back(make_word(BASE + 23'd4, DS_LO, 8'h00, 8'h5A));
    send_byte(25'd8, 8'h5A);
    end_dl("tail");

    // Slow controller, 16 back-to-back strobes
    ack_lat = 20;
    wait_rises = 0;
    cnt_chk_en = 1'b1;
    start_dl("stream");
    w0 = n_writes;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'h80 + 8'(i);
      if (i[0]) sb.push_back(make_word(BASE + 23'(8 + i / 2), DS_BOTH, b, b - 8'd1));
      send_byte(25'(16 + i), b);
    end
    end_dl("stream");
    cnt_chk_en = 1'b0;
    check("stream_writes", 64'(n_writes - w0), 64'd8);
    check("stream_wait_seen", 64'(wait_rises > 0), 64'd1);

    // Two even bytes: flush collision, then tail flush
    ack_lat = 2;
    start_dl("evev");
    wait_rises = 0;
    sb.push_back(make_word(BASE + 23'd0, DS_LO, 8'h00, 8'h61));
    sb.push_back(make_word(BASE + 23'd1, DS_LO, 8'h00, 8'h62));
    send_byte(25'd0, 8'h61);
    send_byte(25'd2, 8'h62);
    end_dl("evev");
    check("evev_wait_pulses", 64'(wait_rises), 64'd1);

    // Even byte then odd byte of a different word
    start_dl("mism");
    sb.push_back(make_word(BASE + 23'd0, DS_LO, 8'h00, 8'h31));
    sb.push_back(make_word(BASE + 23'd1, DS_HI, 8'h44, 8'h00));
    send_byte(25'd0, 8'h31);
    send_byte(25'd3, 8'h44);
    end_dl("mism");

    // Reset while a write is outstanding
    ack_lat = 20;
    start_dl("rstw");
    w0 = n_writes;
    sb.push_back(make_word(BASE + 23'd0, DS_BOTH, 8'h02, 8'h01));
    sb.push_back(make_word(BASE + 23'd1, DS_BOTH, 8'h04, 8'h03));
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    send_byte(25'd2, 8'h03);
    send_byte(25'd3, 8'h04);
    @(negedge clk);
    ioctl_wr = 1'b0;
    t = 0;
    while (n_writes == w0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rstw_issued", 64'(n_writes - w0), 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    check("rstw_req", 64'(port_req), 64'd0);
    check("rstw_empty", 64'(dut.u_fifo.empty), 64'd1);
    check("rstw_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    ack_lat = 3;
    start_dl("after");
    w0 = n_writes;
    sb.push_back(make_word(BASE + 23'd5, DS_BOTH, 8'h88, 8'h77));
    send_byte(25'd10, 8'h77);
    send_byte(25'd11, 8'h88);
    end_dl("after");
    check("after_toggles", 64'(n_writes - w0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
